// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the SPI transmit frame scheduler.
// States name the byte currently presented on tx_data.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_ID      = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_e;

    localparam logic [7:0] HDR_BYTE_DEF  = 8'hA5;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'h00;
    localparam logic [7:0] FILL_BYTE_DEF = 8'h00;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_tx_scheduler_if.sv
// Byte-stream source bundle shared by all producers.
// master = sources, slave = scheduler.
interface spi_tx_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_valid;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;

    modport master (
        output src_valid,
        output src_data,
        output src_last,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_last,
        output src_ready
    );
endinterface

// File: rtl/spi_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr,
// wrapping through index 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    always_comb begin
        logic         found;
        logic [W-1:0] j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Frames round-robin source streams as HDR, ID, payload, XOR checksum
// and presents them byte-by-byte to an SPI slave sender.
module spi_tx_scheduler
    import spi_frame_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEF,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF,
    localparam int        W         = clog2(NUM_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ssel_active,
    input  logic                byte_sent,
    output logic [7:0]          tx_data,
    spi_tx_scheduler_if.slave   src,
    output logic                busy,
    output logic [W-1:0]        grant_id,
    output logic                frame_done,
    output logic                frame_abort,
    output logic                underrun
);

    state_e             state;
    logic [W-1:0]       ptr;
    logic [7:0]         chk;
    logic [7:0]         cnt;
    logic               last_q;
    logic               ssel_q;

    logic [NUM_SRC-1:0] arb_gnt;
    logic [W-1:0]       arb_idx;
    logic [NUM_SRC-1:0] sel_1h;
    logic [W-1:0]       ptr_nxt;
    logic               bnd;
    logic               abort;
    logic               ending;
    logic               fetch;
    logic               cur_valid;
    logic               cur_last;
    logic [7:0]         cur_data;

    rr_arbiter #(
        .N (NUM_SRC),
        .W (W)
    ) u_arb (
        .req (src.src_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign bnd       = byte_sent | ~ssel_active;
    assign abort     = ssel_q & ~ssel_active & (state != ST_IDLE);
    assign ending    = last_q | (cnt == 8'(MAX_LEN));
    assign cur_valid = src.src_valid[grant_id];
    assign cur_last  = src.src_last[grant_id];
    assign cur_data  = src.src_data[{grant_id, 3'b000} +: 8];
    assign busy      = (state != ST_IDLE);
    assign ptr_nxt   = (grant_id == W'(NUM_SRC - 1)) ? '0 : grant_id + W'(1);

    assign fetch = byte_sent &
        ((state == ST_ID) | ((state == ST_PAYLOAD) & ~ending));

    always_comb begin
        sel_1h           = '0;
        sel_1h[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_data       <= IDLE_BYTE;
            ptr           <= '0;
            grant_id      <= '0;
            chk           <= '0;
            cnt           <= '0;
            last_q        <= 1'b0;
            ssel_q        <= 1'b0;
            src.src_ready <= '0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            ssel_q        <= ssel_active;
            src.src_ready <= '0;
            frame_done    <= 1'b0;
            frame_abort   <= 1'b0;
            underrun      <= 1'b0;
            if (abort) begin
                // Select dropped mid-frame: abandon it and move the pointer on.
                state       <= ST_IDLE;
                tx_data     <= IDLE_BYTE;
                frame_abort <= 1'b1;
                ptr         <= ptr_nxt;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bnd && (|arb_gnt)) begin
                            grant_id <= arb_idx;
                            tx_data  <= HDR_BYTE;
                            chk      <= '0;
                            cnt      <= '0;
                            last_q   <= 1'b0;
                            state    <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (byte_sent) begin
                            tx_data <= 8'(grant_id);
                            chk     <= 8'(grant_id);
                            state   <= ST_ID;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_sent && ending) begin
                            tx_data <= chk;
                            state   <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (byte_sent) begin
                            frame_done <= 1'b1;
                            ptr        <= ptr_nxt;
                            tx_data    <= IDLE_BYTE;
                            state      <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
                if (fetch) begin
                    if (cur_valid) begin
                        tx_data       <= cur_data;
                        src.src_ready <= sel_1h;
                        chk           <= chk ^ cur_data;
                        last_q        <= cur_last;
                    end else begin
                        tx_data  <= FILL_BYTE;
                        chk      <= chk ^ FILL_BYTE;
                        underrun <= 1'b1;
                    end
                    cnt   <= cnt + 8'd1;
                    state <= ST_PAYLOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench: expected tx bytes queued by stimulus, popped by monitor.
// Source queues model the producers and consume on src_ready.
module tb_spi_tx_scheduler;

    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ssel_active;
    logic       byte_sent;
    logic [7:0] tx_data;
    logic       busy;
    logic [1:0] grant_id;
    logic       frame_done;
    logic       frame_abort;
    logic       underrun;

    spi_tx_scheduler_if #(.NUM_SRC(4)) sif ();

    spi_tx_scheduler #(
        .NUM_SRC (4),
        .MAX_LEN (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ssel_active (ssel_active),
        .byte_sent   (byte_sent),
        .tx_data     (tx_data),
        .src         (sif),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_abort  = 0;
    int n_under  = 0;
    int n_rdy[4] = '{0, 0, 0, 0};
    bit en[4]    = '{1, 1, 1, 1};
    logic sent_q = 1'b0;

    u8  qd[4][$];
    bit ql[4][$];
    u8  expq[$];
    u8  vec[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Source model: present head of queue, pop on consume pulse
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (en[i] && qd[i].size() > 0) begin
                sif.src_valid[i]      = 1'b1;
                sif.src_data[8*i +: 8] = qd[i][0];
                sif.src_last[i]       = ql[i][0];
            end else begin
                sif.src_valid[i]      = 1'b0;
                sif.src_data[8*i +: 8] = 8'h00;
                sif.src_last[i]       = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        sent_q <= byte_sent;
        for (int i = 0; i < 4; i++) begin
            if (sif.src_ready[i] && qd[i].size() > 0) begin
                void'(qd[i].pop_front());
                void'(ql[i].pop_front());
                n_rdy[i]++;
            end
        end
    end

    // Monitor: one tx byte per boundary, plus pulse tallies
    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (underrun)    n_under++;
        if (sif.src_ready != 4'b0)
            chk("ready_granted_only", sif.src_ready, 32'(4'b1 << grant_id));
        if (sent_q) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else begin
                chk("tx_data", tx_data, expq.pop_front());
            end
        end
    end

    task automatic sb(input u8 e);
        expq.push_back(e);
        @(negedge clk);
        byte_sent = 1'b1;
        @(negedge clk);
        byte_sent = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic play();
        while (vec.size() > 0) sb(vec.pop_front());
    endtask

    task automatic push_src(input int s, input u8 d, input bit l);
        qd[s].push_back(d);
        ql[s].push_back(l);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        ssel_active = 1'b1;
        byte_sent   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx_data, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant_id, 0);
        chk("reset_ready", sif.src_ready, 0);

        // Basic frame from source 2
        push_src(2, 8'h12, 0);
        push_src(2, 8'h34, 0);
        push_src(2, 8'h56, 1);
        vec = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h72, 8'h00};
        play();
        chk("t1_ready2", n_rdy[2], 3);
        chk("t1_done", n_done, 1);
        chk("t1_grant", grant_id, 2);
        chk("t1_busy", busy, 0);

        // Round robin between sources 0 and 1
        push_src(0, 8'h10, 1);
        push_src(0, 8'h11, 1);
        push_src(1, 8'h20, 1);
        push_src(1, 8'h21, 1);
        vec = '{8'hA5, 8'h00, 8'h10, 8'h10, 8'h00};
        play();
        chk("t2_grant_a", grant_id, 0);
        vec = '{8'hA5, 8'h01, 8'h20, 8'h21, 8'h00};
        play();
        chk("t2_grant_b", grant_id, 1);
        vec = '{8'hA5, 8'h00, 8'h11, 8'h11, 8'h00};
        play();
        chk("t2_grant_c", grant_id, 0);
        vec = '{8'hA5, 8'h01, 8'h21, 8'h20, 8'h00};
        play();
        chk("t2_grant_d", grant_id, 1);
        chk("t2_done", n_done, 5);

        // Truncation at MAX_LEN
        for (int k = 1; k <= 20; k++) push_src(1, u8'(k), 0);
        vec = '{8'hA5, 8'h01};
        for (int k = 1; k <= 16; k++) vec.push_back(u8'(k));
        vec.push_back(8'h11);
        vec.push_back(8'h00);
        play();
        chk("t3_ready1", n_rdy[1], 18);
        chk("t3_left", qd[1].size(), 4);
        chk("t3_under", n_under, 0);
        qd[1].delete();
        ql[1].delete();

        // Underrun on the second payload byte
        push_src(0, 8'hAA, 0);
        push_src(0, 8'hBB, 1);
        vec = '{8'hA5, 8'h00, 8'hAA};
        play();
        en[0] = 0;
        sb(8'h00);
        en[0] = 1;
        vec = '{8'hBB, 8'h11, 8'h00};
        play();
        chk("t4_under", n_under, 1);
        chk("t4_ready0", n_rdy[0], 4);

        // Abort in PAYLOAD coincident with byte_sent
        en[1] = 0;
        push_src(0, 8'hB0, 0);
        push_src(0, 8'hB1, 0);
        push_src(0, 8'hB2, 0);
        push_src(1, 8'hC0, 1);
        vec = '{8'hA5, 8'h00, 8'hB0};
        play();
        en[1] = 1;
        expq.push_back(8'h00);
        @(negedge clk);
        byte_sent   = 1'b1;
        ssel_active = 1'b0;
        @(negedge clk);
        byte_sent = 1'b0;
        chk("t5_abort_pulse", frame_abort, 1);
        chk("t5_abort_ready", sif.src_ready, 0);
        chk("t5_ready0", n_rdy[0], 5);
        @(negedge clk);
        chk("t5_next_grant", grant_id, 1);
        chk("t5_next_hdr", tx_data, 8'hA5);
        ssel_active = 1'b1;
        qd[0].delete();
        ql[0].delete();
        repeat (2) @(negedge clk);
        chk("t5_abort_cnt", n_abort, 1);
        vec = '{8'h01, 8'hC0, 8'hC1, 8'h00};
        play();
        chk("t5_done", n_done, 8);

        // Reset while in ID
        push_src(3, 8'hD0, 1);
        vec = '{8'hA5, 8'h03};
        play();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_tx", tx_data, 8'h00);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", n_done, 8);
        chk("t6_no_abort", n_abort, 1);
        push_src(1, 8'hE0, 1);
        vec = '{8'hA5, 8'h01, 8'hE0, 8'hE1, 8'h00};
        play();
        chk("t6_ptr_zero", grant_id, 1);
        chk("t6_ready3", n_rdy[3], 0);
        chk("t6_ready1", n_rdy[1], 20);

        repeat (4) @(negedge clk);
        chk("exp_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
